// File: rtl/pixel_sink.sv
// Pixel write sink: FIFO-buffered, clipped x/y -> linear framebuffer writes with memory stall.
// Define FB_CLEAR_EN to compile in the full-screen clear engine (CLEAR state, sweep counter).
module pixel_sink #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEn,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [2:0]        colour,
  output logic              ready,
  input  logic              clear,
  input  logic [2:0]        clear_colour,
  input  logic              mem_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic [7:0]        drop_count,
  output logic              state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic {ST_NORMAL = 1'b0, ST_CLEAR = 1'b1} state_t;

  // Handshakes: a pixel is taken on a rising edge when writeEn & ready and it lies on screen;
  // a memory write completes on a rising edge when mem_wren & !mem_stall.
  logic [ADDR_W+2:0] fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        drop_q;
  logic [ADDR_W-1:0] mem_addr_q, pix_addr, head_addr;
  logic [2:0]        mem_data_q, head_col;
  logic              mem_wren_q;
  state_t            state_q;

  logic full, empty, in_range, push, pop, drop;
  logic out_free, clear_go, clear_done, draining, clear_busy;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_range = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
  assign pix_addr = ADDR_W'(32'(y) * WIDTH + 32'(x));
  assign push     = writeEn && in_range && !full;
  assign drop     = writeEn && (!in_range || full);
  assign {head_addr, head_col} = fifo_mem_q[rd_ptr_q];

  assign out_free = !(mem_wren_q && mem_stall);

`ifdef FB_CLEAR_EN
  logic             clear_pend_q;
  logic [2:0]       clr_col_q;
  logic [CNT_W-1:0] cnt_q;

  assign clear_go   = (state_q == ST_NORMAL) && out_free && (clear || clear_pend_q);
  assign clear_done = (state_q == ST_CLEAR) && (cnt_q == CNT_W'(TOTAL));
  assign clear_busy = (state_q == ST_CLEAR) || clear_pend_q;
`else
  logic unused_clear;
  assign unused_clear = ^{clear, clear_colour};
  assign clear_go     = 1'b0;
  assign clear_done   = 1'b0;
  assign clear_busy   = 1'b0;
`endif

  // The FIFO feeds the output register only in NORMAL, or on the very edge the sweep finishes.
  assign draining = out_free && !clear_go && ((state_q == ST_NORMAL) || clear_done);
  assign pop      = draining && !empty;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {pix_addr, colour};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_NORMAL;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
`ifdef FB_CLEAR_EN
      clear_pend_q <= 1'b0;
      clr_col_q    <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      if (draining) begin
        if (!empty) begin
          mem_addr_q <= head_addr;
          mem_data_q <= head_col;
          mem_wren_q <= 1'b1;
        end else begin
          mem_wren_q <= 1'b0;
        end
      end
`ifdef FB_CLEAR_EN
      if (state_q == ST_NORMAL) begin
        if (clear_go) begin
          // First sweep write (address 0) is loaded on the accepting edge.
          state_q      <= ST_CLEAR;
          clear_pend_q <= 1'b0;
          clr_col_q    <= clear_pend_q ? clr_col_q : clear_colour;
          mem_addr_q   <= '0;
          mem_data_q   <= clear_pend_q ? clr_col_q : clear_colour;
          mem_wren_q   <= 1'b1;
          cnt_q        <= CNT_W'(1);
        end else if (clear && !clear_pend_q) begin
          clear_pend_q <= 1'b1;
          clr_col_q    <= clear_colour;
        end
      end else if (out_free) begin
        if (clear_done) begin
          state_q <= ST_NORMAL;
        end else begin
          mem_addr_q <= ADDR_W'(cnt_q);
          mem_data_q <= clr_col_q;
          mem_wren_q <= 1'b1;
          cnt_q      <= cnt_q + CNT_W'(1);
        end
      end
`endif
    end
  end

  assign ready      = !full;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wren   = mem_wren_q;
  assign busy       = !empty || mem_wren_q || clear_busy;
  assign drop_count = drop_q;
  assign state_dbg  = (state_q == ST_CLEAR);

endmodule
